// File: rtl/stats_counter_accum.sv
// Per-ID statistics accumulator: adds AXI-stream increments into RAM-held counters and serves control-side reads.
// Latency: one cycle from acceptance to RAM write-back; a read result strobes two cycles after acceptance.
// Backpressure: tready drops during the INIT clear sweep and whenever a read is requested (reads take priority).
module stats_counter_accum #(
    parameter int STAT_INC_WIDTH   = 24,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [STAT_INC_WIDTH-1:0]   s_axis_stat_tdata,
    input  logic [STAT_ID_WIDTH-1:0]    s_axis_stat_tid,
    input  logic                        s_axis_stat_tvalid,
    output logic                        s_axis_stat_tready,

    input  logic [STAT_ID_WIDTH-1:0]    ctrl_rd_addr,
    input  logic                        ctrl_rd_en,
    output logic                        ctrl_rd_ready,
    output logic [STAT_COUNT_WIDTH-1:0] ctrl_rd_data,
    output logic                        ctrl_rd_valid
);

    localparam int NUM_CNT = 1 << STAT_ID_WIDTH;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [STAT_ID_WIDTH-1:0]    init_idx_q, init_idx_d;

    // Stage 1: operation accepted in the previous cycle.
    logic                        s1_vld_q, s1_vld_d;
    logic                        s1_rd_q, s1_rd_d;
    logic [STAT_ID_WIDTH-1:0]    s1_idx_q, s1_idx_d;
    logic [STAT_INC_WIDTH-1:0]   s1_inc_q, s1_inc_d;

    // Last committed update, replayed when RAM output is one write stale.
    logic                        fwd_vld_q;
    logic [STAT_ID_WIDTH-1:0]    fwd_idx_q;
    logic [STAT_COUNT_WIDTH-1:0] fwd_dat_q;

    logic                        rd_vld_q;
    logic [STAT_COUNT_WIDTH-1:0] rd_dat_q;

    logic [STAT_COUNT_WIDTH-1:0] mem [0:NUM_CNT-1];
    logic [STAT_COUNT_WIDTH-1:0] ram_rdat_q;

    logic                        run;
    logic                        upd_fire;
    logic                        rd_fire;
    logic [STAT_ID_WIDTH-1:0]    ram_raddr;
    logic                        ram_we;
    logic [STAT_ID_WIDTH-1:0]    ram_waddr;
    logic [STAT_COUNT_WIDTH-1:0] ram_wdat;
    logic                        upd_commit;
    logic [STAT_COUNT_WIDTH-1:0] base;
    logic [STAT_COUNT_WIDTH-1:0] sum;

    // Handshakes: nothing is accepted while clearing or while reset is asserted; reads outrank updates.
    always_comb begin
        run                = (state_q == S_RUN) && !rst;
        ctrl_rd_ready      = run;
        s_axis_stat_tready = run && !ctrl_rd_en;
        rd_fire            = ctrl_rd_en && ctrl_rd_ready;
        upd_fire           = s_axis_stat_tvalid && s_axis_stat_tready;
        ram_raddr          = rd_fire ? ctrl_rd_addr : s_axis_stat_tid;
    end

    // INIT sweeps every index once, then hands over to RUN.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // FSM and sweep index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Next contents of stage 1: the op accepted this cycle, if any.
    always_comb begin
        s1_vld_d = upd_fire || rd_fire;
        s1_rd_d  = rd_fire;
        s1_idx_d = ram_raddr;
        s1_inc_d = s_axis_stat_tdata;
    end

    // Stage 1 register; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_rd_q  <= 1'b0;
            s1_idx_q <= '0;
            s1_inc_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_rd_q  <= s1_rd_d;
            s1_idx_q <= s1_idx_d;
            s1_inc_q <= s1_inc_d;
        end
    end

    // Base value selection and wrap-around accumulate; RAM write mux between sweep and update.
    always_comb begin
        base       = (fwd_vld_q && (fwd_idx_q == s1_idx_q)) ? fwd_dat_q : ram_rdat_q;
        sum        = base + STAT_COUNT_WIDTH'(s1_inc_q);
        upd_commit = s1_vld_q && !s1_rd_q && !rst;
        ram_we     = ((state_q == S_INIT) && !rst) || upd_commit;
        ram_waddr  = (state_q == S_INIT) ? init_idx_q : s1_idx_q;
        ram_wdat   = (state_q == S_INIT) ? '0 : sum;
    end

    // Counter storage: synchronous read returns pre-write data on an address clash.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdat;
        end
        ram_rdat_q <= mem[ram_raddr];
    end

    // Capture each committed update so the next op on the same index sees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_vld_q <= 1'b0;
            fwd_idx_q <= '0;
            fwd_dat_q <= '0;
        end else begin
            fwd_vld_q <= upd_commit;
            if (upd_commit) begin
                fwd_idx_q <= s1_idx_q;
                fwd_dat_q <= sum;
            end
        end
    end

    // Read result: one-cycle strobe, data held until the next read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= s1_vld_q && s1_rd_q;
            if (s1_vld_q && s1_rd_q) begin
                rd_dat_q <= base;
            end
        end
    end

    assign ctrl_rd_valid = rd_vld_q;
    assign ctrl_rd_data  = rd_dat_q;

endmodule

// File: doc/stats_counter_accum.md
Name: stats_counter_accum

Overview:
Consumer end of the statistics increment stream produced by the PCIe stats collectors. Accepts (tid, tdata) increments over AXI-stream and accumulates each into a wide per-ID counter held in block RAM, using a 1-cycle read-modify-write pipeline with write-to-read forwarding. Exposes a read port so the register block can fetch counter values. Sits between the stats_collect output and the control register file.

Parameters:
STAT_INC_WIDTH, 24, width of incoming increment (s_axis_stat_tdata)
STAT_ID_WIDTH, 5, width of counter ID; counter count = 2**STAT_ID_WIDTH
STAT_COUNT_WIDTH, 64, width of each accumulated counter; must be >= STAT_INC_WIDTH

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
s_axis_stat_tdata  input  STAT_INC_WIDTH  increment value
s_axis_stat_tid  input  STAT_ID_WIDTH  counter index
s_axis_stat_tvalid  input  1  increment valid
s_axis_stat_tready  output  1  increment accepted when tvalid && tready
ctrl_rd_addr  input  STAT_ID_WIDTH  counter index to read
ctrl_rd_en  input  1  read request
ctrl_rd_ready  output  1  read accepted when ctrl_rd_en && ctrl_rd_ready
ctrl_rd_data  output  STAT_COUNT_WIDTH  counter value
ctrl_rd_valid  output  1  single-cycle strobe, ctrl_rd_data valid

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- States: INIT, RUN.
- INIT: entered on any cycle with rst=1. Sweeps index 0..2**STAT_ID_WIDTH-1, writing 0 at one index per cycle, starting the first cycle after rst deasserts. Enters RUN after the last index is written. Default sweep takes 32 cycles.
- Reset values: s_axis_stat_tready=0, ctrl_rd_ready=0, ctrl_rd_valid=0, ctrl_rd_data=0. All pipeline valid bits and the forwarding register are cleared.
- tready = (state==RUN) && !ctrl_rd_en. Reads have strict priority; an update is stalled in any cycle a read is requested. Reads are never stalled in RUN.
- ctrl_rd_ready = (state==RUN).
- Pipeline, for an operation accepted at cycle T:
  - Cycle T: RAM read address = tid or rd_addr. The op is registered into stage 1.
  - Cycle T+1: base = forward hit ? fwd_data : RAM output. Forward hit = the write committed at the end of cycle T targeted the same index. RAM read-during-write returns old data, so forwarding is mandatory.
  - Update op: sum = base + zero-extended inc, modulo 2**STAT_COUNT_WIDTH (wraps, no saturation). Written to RAM at the end of T+1. {index, sum} are also captured as fwd for the next cycle.
  - Read op: base is registered to ctrl_rd_data, and ctrl_rd_valid=1 in cycle T+2 for exactly one cycle. ctrl_rd_data holds its value until the next read result.
- Throughput: one operation per cycle, updates and reads combined. Back-to-back updates to the same ID accumulate exactly.
- A read accepted in cycle T+1, immediately after an update to the same ID accepted in T, returns the post-update value.
- Reset mid-operation: in-flight ops are discarded. No ctrl_rd_valid is issued for reads accepted before rst. The RAM is fully re-cleared by a fresh INIT sweep.
- tvalid must not depend on tready. Data on the stat interface is held stable while tvalid && !tready (AXI-stream rules).

Test Plan:
- Reset: pulse rst 1 cycle -> tready and ctrl_rd_ready = 0 for exactly 32 cycles, then 1. Read IDs 0..31 -> all return 0, each with ctrl_rd_valid 2 cycles after acceptance.
- Single update: tid=3, tdata=100 accepted; read ID 3 next cycle -> ctrl_rd_data=100.
- Forwarding: updates on ID 7 of 5, 6, 7 in consecutive cycles, then a read of 7 in the following cycle -> 18. Repeat interleaved with ID 8 (7:1, 8:2, 7:4) -> ID7=5, ID8=2.
- Wrap: STAT_COUNT_WIDTH=32, 257 updates of 0xFFFFFF to ID 0 -> read returns 0x00FFFEFF.
- Collision: tvalid (ID 2, +10) and ctrl_rd_en (ID 2) in the same cycle, counter previously 40 -> tready=0 that cycle. Read returns 40; update accepted next cycle; later read returns 50.
- Reset mid-stream: counters nonzero and a read in flight, rst asserted 1 cycle -> no ctrl_rd_valid for the in-flight read. A 32-cycle INIT follows, then all IDs read 0.
